// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch/jump control unit: op kinds, condition codes,
// PSR bit positions and the redirect FSM states.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_BCOND = 2'b01,
        OP_JCOND = 2'b10,
        OP_JAL   = 2'b11
    } op_kind_t;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int PSR_W = 5;
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_SQUASH
    } state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/fetch-facing signals of branch_ctrl. master = pipeline side, slave = branch_ctrl.
interface branch_ctrl_if;
    import branch_ctrl_pkg::*;

    logic             flags_we;
    logic [PSR_W-1:0] flags_in;
    logic             instr_valid;
    logic [1:0]       op_kind;
    logic [3:0]       cond;
    logic             stall;
    logic             redirect_ack;
    logic             branchEN;
    logic             jumpEN;
    logic             jalEN;
    logic             flush;
    logic             busy;
    logic [PSR_W-1:0] psr;

    modport master (
        output flags_we, flags_in, instr_valid, op_kind, cond, stall, redirect_ack,
        input  branchEN, jumpEN, jalEN, flush, busy, psr
    );

    modport slave (
        input  flags_we, flags_in, instr_valid, op_kind, cond, stall, redirect_ack,
        output branchEN, jumpEN, jalEN, flush, busy, psr
    );

endinterface

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational condition-code evaluator; shared with future predicated-execution logic.
module cond_eval
    import branch_ctrl_pkg::*;
(
    input  logic [3:0]       cond,
    input  logic [PSR_W-1:0] flags,
    output logic             taken
);

    logic c, l, f, z, n;

    assign c = flags[PSR_C];
    assign l = flags[PSR_L];
    assign f = flags[PSR_F];
    assign z = flags[PSR_Z];
    assign n = flags[PSR_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = z;
            CC_NE:   taken = !z;
            CC_CS:   taken = c;
            CC_CC:   taken = !c;
            CC_HI:   taken = l;
            CC_LS:   taken = !l;
            CC_GT:   taken = n;
            CC_LE:   taken = !n;
            CC_FS:   taken = f;
            CC_FC:   taken = !f;
            CC_LO:   taken = !l && !z;
            CC_HS:   taken = l || z;
            CC_LT:   taken = !n && !z;
            CC_GE:   taken = n || z;
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump control: PSR register, condition evaluation and the
// redirect -> squash handshake with fetch.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    branch_ctrl_if.slave   bus
);

    if (SQUASH_CYCLES < 1 || SQUASH_CYCLES > 7 || WIDTH < 1) begin : g_param_chk
        $error("branch_ctrl: SQUASH_CYCLES must be 1..7");
    end

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    state_t           state;
    logic [2:0]       cnt;
    logic [PSR_W-1:0] eff_flags;
    logic             cc_taken;
    logic             go;

    // Forward a same-cycle PSR write into the evaluation.
    assign eff_flags = bus.flags_we ? bus.flags_in : bus.psr;

    cond_eval u_cond_eval (
        .cond  (bus.cond),
        .flags (eff_flags),
        .taken (cc_taken)
    );

    assign go = bus.instr_valid && !bus.stall && (bus.op_kind != OP_NONE) &&
                ((bus.op_kind == OP_JAL) || cc_taken);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            bus.psr      <= '0;
            bus.branchEN <= 1'b0;
            bus.jumpEN   <= 1'b0;
            bus.jalEN    <= 1'b0;
            bus.flush    <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            if (bus.flags_we)
                bus.psr <= bus.flags_in;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        bus.branchEN <= (bus.op_kind == OP_BCOND);
                        bus.jumpEN   <= (bus.op_kind == OP_JCOND);
                        bus.jalEN    <= (bus.op_kind == OP_JAL);
                        bus.busy     <= 1'b1;
                        state        <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ack && !bus.stall) begin
                        bus.branchEN <= 1'b0;
                        bus.jumpEN   <= 1'b0;
                        bus.jalEN    <= 1'b0;
                        bus.flush    <= 1'b1;
                        cnt          <= SQ_LOAD;
                        state        <= S_SQUASH;
                    end
                end
                S_SQUASH: begin
                    if (!bus.stall) begin
                        if (cnt == 3'd1) begin
                            bus.flush <= 1'b0;
                            bus.busy  <= 1'b0;
                            cnt       <= 3'd0;
                            state     <= S_IDLE;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    localparam int SQ = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    branch_ctrl_if bif ();

    branch_ctrl #(.WIDTH(16), .SQUASH_CYCLES(SQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    logic [3:0] sw_cond;
    logic [4:0] sw_flags;
    logic       sw_taken;

    cond_eval u_sweep (.cond(sw_cond), .flags(sw_flags), .taken(sw_taken));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending redirect kind (0 = none) and flush cycles left
    logic [4:0] m_psr;
    int         m_kind;
    int         m_sq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] c, input logic [4:0] fl);
        bit C, L, F, Z, N;
        C = fl[4]; L = fl[3]; F = fl[2]; Z = fl[1]; N = fl[0];
        case (c)
            4'd0:  return Z;
            4'd1:  return !Z;
            4'd2:  return C;
            4'd3:  return !C;
            4'd4:  return L;
            4'd5:  return !L;
            4'd6:  return N;
            4'd7:  return !N;
            4'd8:  return F;
            4'd9:  return !F;
            4'd10: return !L && !Z;
            4'd11: return L || Z;
            4'd12: return !N && !Z;
            4'd13: return N || Z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_step();
        logic [4:0] eff;
        bit tk;
        eff = bif.flags_we ? bif.flags_in : m_psr;
        tk  = (bif.op_kind == 2'd3) || ref_taken(bif.cond, eff);
        if (m_kind != 0) begin
            if (bif.redirect_ack && !bif.stall) begin
                m_kind = 0;
                m_sq   = SQ;
            end
        end else if (m_sq > 0) begin
            if (!bif.stall) m_sq--;
        end else if (bif.instr_valid && bif.op_kind != 2'd0 && !bif.stall && tk) begin
            m_kind = int'(bif.op_kind);
        end
        if (bif.flags_we) m_psr = bif.flags_in;
    endfunction

    task automatic compare();
        chk("psr",      bif.psr,      m_psr);
        chk("branchEN", bif.branchEN, m_kind == 1);
        chk("jumpEN",   bif.jumpEN,   m_kind == 2);
        chk("jalEN",    bif.jalEN,    m_kind == 3);
        chk("flush",    bif.flush,    m_sq > 0);
        chk("busy",     bif.busy,     (m_kind != 0) || (m_sq > 0));
        chk("onehot",   $countones({bif.branchEN, bif.jumpEN, bif.jalEN}) <= 1, 1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle_in();
        bif.flags_we = 0; bif.flags_in = '0; bif.instr_valid = 0; bif.op_kind = 2'd0;
        bif.cond = 4'd0; bif.stall = 0; bif.redirect_ack = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_psr = '0; m_kind = 0; m_sq = 0;
        compare();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && bif.busy; i++) cyc();
        chk("drain_timeout", bif.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en, fl, st;
        idle_in();
        do_reset();

        // forwarded Z taken by EQ
        bif.flags_we = 1; bif.flags_in = 5'b00010;
        bif.instr_valid = 1; bif.op_kind = 2'd1; bif.cond = 4'h0;
        cyc();
        chk("fwd_eq_branchEN", bif.branchEN, 1);
        idle_in(); bif.redirect_ack = 1;
        drain();

        // forwarded Z rejects NE
        bif.flags_we = 1; bif.flags_in = 5'b00010;
        bif.instr_valid = 1; bif.op_kind = 2'd1; bif.cond = 4'h1;
        cyc();
        chk("fwd_ne_busy", bif.busy, 0);
        chk("fwd_ne_branchEN", bif.branchEN, 0);

        // Jcond LO with L=Z=0, ack held off 3 cycles
        idle_in(); bif.flags_we = 1; bif.flags_in = 5'b00000;
        cyc();
        idle_in(); bif.instr_valid = 1; bif.op_kind = 2'd2; bif.cond = 4'hA;
        cyc();
        idle_in();
        en = 0; fl = 0;
        for (int i = 0; i < 20 && bif.busy; i++) begin
            if (bif.jumpEN) en++;
            if (bif.flush)  fl++;
            bif.redirect_ack = (en >= 4);
            cyc();
        end
        chk("jcond_en_cycles", en, 4);
        chk("jcond_flush_cycles", fl, SQ);
        chk("jcond_busy_end", bif.busy, 0);

        // JAL ignores cond; Bcond NV never taken
        idle_in(); bif.instr_valid = 1; bif.op_kind = 2'd3; bif.cond = 4'hF;
        cyc();
        chk("jal_taken", bif.jalEN, 1);
        idle_in(); bif.redirect_ack = 1;
        drain();
        idle_in(); bif.instr_valid = 1; bif.op_kind = 2'd1; bif.cond = 4'hF;
        cyc();
        chk("nv_not_taken", bif.busy, 0);

        // stall in REDIRECT holds the enable even with ack
        idle_in(); bif.instr_valid = 1; bif.op_kind = 2'd1; bif.cond = 4'hE;
        cyc();
        idle_in(); bif.redirect_ack = 1; bif.stall = 1;
        cyc(); cyc();
        chk("stall_hold_en", bif.branchEN, 1);
        bif.stall = 0;
        drain();

        // stall 2 cycles in SQUASH; instr_valid while busy is ignored
        idle_in(); bif.instr_valid = 1; bif.op_kind = 2'd1; bif.cond = 4'hE;
        cyc();
        bif.redirect_ack = 1;
        en = 0; fl = 0; st = 0;
        for (int i = 0; i < 20 && bif.busy; i++) begin
            if (bif.branchEN) en++;
            if (bif.flush)    fl++;
            bif.stall = bif.flush && (st < 2);
            if (bif.stall) st++;
            cyc();
        end
        idle_in();
        chk("busy_ignore_en", en, 1);
        chk("stall_flush_cycles", fl, SQ + 2);

        // reset mid-REDIRECT
        idle_in(); bif.flags_we = 1; bif.flags_in = 5'h1F;
        bif.instr_valid = 1; bif.op_kind = 2'd3;
        cyc();
        idle_in();
        cyc();
        do_reset();
        chk("rst_psr", bif.psr, 0);
        chk("rst_jal", bif.jalEN, 0);
        bif.instr_valid = 1; bif.op_kind = 2'd2; bif.cond = 4'hE;
        cyc();
        chk("rst_idle_accept", bif.jumpEN, 1);
        idle_in(); bif.redirect_ack = 1;
        drain();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bif.flags_we     = ($urandom_range(0, 3) == 0);
            bif.flags_in     = 5'($urandom);
            bif.instr_valid  = 1'($urandom_range(0, 1));
            bif.op_kind      = 2'($urandom);
            bif.cond         = 4'($urandom);
            bif.stall        = ($urandom_range(0, 4) == 0);
            bif.redirect_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc();
        end
        idle_in();

        // exhaustive evaluator sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                sw_cond = 4'(c); sw_flags = 5'(f);
                #1;
                chk($sformatf("cond_eval_%0h_%02h", c, f), sw_taken, ref_taken(sw_cond, sw_flags));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch/jump control unit for the 16-bit datapath. It holds the processor status register (PSR) flags and evaluates the 4-bit condition field of Bcond/Jcond instructions against them. It issues registered, mutually exclusive `branchEN`/`jumpEN`/`jalEN` redirect requests to the PC-update logic and runs a redirect/squash handshake with fetch. It sits between decode and the next-PC adder and produces the enables that adder consumes.

## Interface
- `WIDTH`, 16: datapath width; carried for consistency, no internal arithmetic at this width.
- `SQUASH_CYCLES`, 2: cycles `flush` is held after a redirect is acknowledged; legal range 1–7.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flags_we`  in  1  PSR write enable.
- `flags_in`  in  5  new flags `{C,L,F,Z,N}`, bit 4 = C.
- `instr_valid`  in  1  decode presents a control-flow candidate.
- `op_kind`  in  2  00 none, 01 Bcond, 10 Jcond, 11 JAL.
- `cond`  in  4  condition code.
- `stall`  in  1  pipeline hold; freezes FSM and counter.
- `redirect_ack`  in  1  fetch has consumed the redirect.
- `branchEN`, `jumpEN`, `jalEN`  out  1 each  registered redirect requests, at most one high.
- `flush`  out  1  squash younger instructions.
- `busy`  out  1  high in any state other than IDLE.
- `psr`  out  5  current flags `{C,L,F,Z,N}`.

## Operation
- The PSR register loads `flags_in` on `flags_we`, in every state and ignoring `stall`.
- Condition evaluation uses effective flags: `flags_in` when `flags_we` is high in the same cycle (forwarding), otherwise `psr`.
- Condition truth:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 HI: L.
  - 0101 LS: !L.
  - 0110 GT: N.
  - 0111 LE: !N.
  - 1000 FS: F.
  - 1001 FC: !F.
  - 1010 LO: !L&!Z.
  - 1011 HS: L|Z.
  - 1100 LT: !N&!Z.
  - 1101 GE: N|Z.
  - 1110 UC: 1.
  - 1111: never.
- JAL is always taken and ignores `cond`.
- FSM states:
  - IDLE: if `instr_valid & op_kind!=0 & !stall` and the instruction is taken, set the matching enable and go to REDIRECT. If not taken, stay in IDLE with no output change.
  - REDIRECT: hold the enable until `redirect_ack & !stall`. Then clear the enable, load the counter with `SQUASH_CYCLES`, and go to SQUASH.
  - SQUASH: `flush`=1; decrement the counter each non-stalled cycle. When the counter reaches 1 on a non-stalled cycle, go to IDLE.
- `instr_valid` is ignored while `busy`; upstream holds or squashes the instruction.
- `redirect_ack` is ignored outside REDIRECT.
- `reset_n` low at any time, including mid-REDIRECT or mid-SQUASH: return to IDLE immediately and clear all outputs.

## Timing
- Reset values: `psr`=0, all enables 0, `flush`=0, `busy`=0, counter 0.
- Evaluate in cycle N; the enable is visible from cycle N+1 (one-cycle latency) and `busy` rises at N+1.
- If `redirect_ack` is high at N+1, the enable is a one-cycle pulse and `flush` is high for N+2 through N+1+SQUASH_CYCLES. `busy` falls after that, and a new instruction is accepted the cycle `busy` is low.
- A PSR write at cycle N is visible on `psr` at N+1; an evaluation at N sees it through forwarding.
- `stall` in REDIRECT holds the enable high even if `redirect_ack` is asserted.

## Structure
- Shared package: `op_kind` encodings, 4-bit condition-code constants, PSR bit indices (C=4, L=3, F=2, Z=1, N=0), and the FSM state enum.
- One sub-module: `cond_eval`, purely combinational. Inputs are `cond` and the 5 flags; output is `taken`. It is reused by any later predicated-execution logic.
- The FSM, PSR register and squash counter live in `branch_ctrl`.

## Test plan
- Reset with `reset_n`=0 mid-REDIRECT -> all outputs 0 immediately, `psr`=0; after release, state is IDLE.
- `flags_we`=1, `flags_in`=5'b00010 with Bcond `cond`=0000 in the same cycle -> `branchEN`=1 next cycle (forwarded Z); `cond`=0001 instead -> no enable, `busy` stays 0.
- Jcond `cond`=1010 with `psr` L=0, Z=0; `redirect_ack` held low 3 cycles then high -> `jumpEN` high 4 cycles, then `flush` high 2 cycles, then `busy`=0.
- JAL with `cond`=1111 -> `jalEN`=1 (cond ignored); Bcond `cond`=1111 -> never taken.
- In SQUASH, `stall`=1 for 2 cycles -> `flush` extends to 4 cycles total; `instr_valid` during `busy` produces no enable.
- Sweep all 16 conds × 32 flag values through `cond_eval` against the truth list -> zero mismatches; enables never more than one high.
